// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param
// Description : Parametrised up/down event counter with programmable modulus,
//               wrap or saturate behaviour at the range limits, an enable
//               prescaler, a terminal-count pulse, boundary flags, sticky
//               overflow/underflow flags and a load range-error pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH    - counter width in bits (>= 2)
//   MOD_MAX  - highest count value, range is 0..MOD_MAX (<= 2**WIDTH-1)
//   SAT_MODE - 0 = wrap at the limits, 1 = saturate at the limits
//   PRESCALE - enabled edges per count step (>= 1)
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   clr      in   synchronous clear of count, prescaler and all flags
//   load     in   load data into count
//   data     in   load value (WIDTH bits)
//   en       in   count enable
//   up_dn    in   direction, 1 = up, 0 = down
//   count    out  registered count value
//   tc       out  registered one-cycle terminal-count pulse
//   at_max   out  count == MOD_MAX (combinational)
//   at_min   out  count == 0 (combinational)
//   ovf      out  sticky: up-step taken at MOD_MAX
//   unf      out  sticky: down-step taken at 0
//   load_err out  one-cycle pulse: load value was above MOD_MAX
// ============================================================================
module updown_counter_param #(
  parameter int WIDTH    = 8,
  parameter int MOD_MAX  = 2**WIDTH - 1,
  parameter int SAT_MODE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf,
  output logic             load_err
);

  // Prescaler needs at least one bit even when PRESCALE == 1.
  localparam int             c_PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0]  c_PTERM   = c_PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] c_MOD_MAX = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [c_PW-1:0]  r_presc;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;
  logic             r_load_err;

  logic             w_at_max;
  logic             w_at_min;
  logic             w_presc_term;
  logic             w_load_oor;

  assign w_at_max     = (r_count == c_MOD_MAX);
  assign w_at_min     = (r_count == '0);
  assign w_presc_term = (r_presc == c_PTERM);
  assign w_load_oor   = (data > c_MOD_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_presc    <= '0;
      r_tc       <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_load_err <= 1'b0;
    end else if (clr) begin
      r_count    <= '0;
      r_presc    <= '0;
      r_tc       <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      // Both pulses drop unless this edge re-asserts them below.
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
      if (load) begin
        r_presc <= '0;
        if (w_load_oor) begin
          // Out-of-range loads clamp to the top of the range.
          r_count    <= c_MOD_MAX;
          r_load_err <= 1'b1;
        end else begin
          r_count <= data;
        end
      end else if (en) begin
        if (w_presc_term) begin
          r_presc <= '0;
          if (up_dn) begin
            if (w_at_max) begin
              r_tc    <= 1'b1;
              r_ovf   <= 1'b1;
              r_count <= (SAT_MODE != 0) ? c_MOD_MAX : '0;
            end else begin
              r_count <= r_count + c_ONE;
            end
          end else begin
            if (w_at_min) begin
              r_tc    <= 1'b1;
              r_unf   <= 1'b1;
              r_count <= (SAT_MODE != 0) ? '0 : c_MOD_MAX;
            end else begin
              r_count <= r_count - c_ONE;
            end
          end
        end else begin
          r_presc <= r_presc + c_PW'(1);
        end
      end
    end
  end

  assign count    = r_count;
  assign tc       = r_tc;
  assign at_max   = w_at_max;
  assign at_min   = w_at_min;
  assign ovf      = r_ovf;
  assign unf      = r_unf;
  assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_param
// Description : Bench for updown_counter_param. Four instances share one
//               stimulus stream: defaults, MOD_MAX=9 wrap, MOD_MAX=9
//               saturate, and PRESCALE=3. A behavioural model per instance
//               tracks the expected state; directed scenarios also check
//               literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       reset, clr, load, en, up_dn;
  logic [7:0] data;

  logic [7:0] o_count [4];
  logic       o_tc [4], o_at_max [4], o_at_min [4];
  logic       o_ovf [4], o_unf [4], o_le [4];

  // Model state and per-instance configuration.
  int m_cnt [4], m_pre [4];
  bit m_tc [4], m_ovf [4], m_unf [4], m_le [4];
  int P_MAX [4] = '{255, 9, 9, 255};
  int P_SAT [4] = '{0, 0, 1, 0};
  int P_PRE [4] = '{1, 1, 1, 3};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  updown_counter_param u_def (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .data(data), .en(en),
    .up_dn(up_dn), .count(o_count[0]), .tc(o_tc[0]), .at_max(o_at_max[0]),
    .at_min(o_at_min[0]), .ovf(o_ovf[0]), .unf(o_unf[0]), .load_err(o_le[0]));

  updown_counter_param #(.WIDTH(8), .MOD_MAX(9), .SAT_MODE(0)) u_m9w (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .data(data), .en(en),
    .up_dn(up_dn), .count(o_count[1]), .tc(o_tc[1]), .at_max(o_at_max[1]),
    .at_min(o_at_min[1]), .ovf(o_ovf[1]), .unf(o_unf[1]), .load_err(o_le[1]));

  updown_counter_param #(.WIDTH(8), .MOD_MAX(9), .SAT_MODE(1)) u_m9s (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .data(data), .en(en),
    .up_dn(up_dn), .count(o_count[2]), .tc(o_tc[2]), .at_max(o_at_max[2]),
    .at_min(o_at_min[2]), .ovf(o_ovf[2]), .unf(o_unf[2]), .load_err(o_le[2]));

  updown_counter_param #(.WIDTH(8), .PRESCALE(3)) u_ps3 (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .data(data), .en(en),
    .up_dn(up_dn), .count(o_count[3]), .tc(o_tc[3]), .at_max(o_at_max[3]),
    .at_min(o_at_min[3]), .ovf(o_ovf[3]), .unf(o_unf[3]), .load_err(o_le[3]));

  // Behavioural model: applies the documented per-edge rules to the inputs
  // present at the rising edge. The step rule is expressed as "every
  // PRESCALE-th enabled edge" and wrapping as arithmetic modulo MOD_MAX+1.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      if (reset || clr) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0;
        m_ovf[i] = 0; m_unf[i] = 0; m_le[i] = 0;
      end else begin
        m_tc[i] = 0;
        m_le[i] = 0;
        if (load) begin
          m_pre[i] = 0;
          if (int'(data) > P_MAX[i]) begin
            m_cnt[i] = P_MAX[i];
            m_le[i]  = 1;
          end else begin
            m_cnt[i] = int'(data);
          end
        end else if (en) begin
          m_pre[i] = m_pre[i] + 1;
          if (m_pre[i] == P_PRE[i]) begin
            m_pre[i] = 0;
            if (up_dn) begin
              if (m_cnt[i] == P_MAX[i]) begin
                m_tc[i] = 1; m_ovf[i] = 1;
                m_cnt[i] = P_SAT[i] ? P_MAX[i] : (m_cnt[i] + 1) % (P_MAX[i] + 1);
              end else begin
                m_cnt[i] = m_cnt[i] + 1;
              end
            end else begin
              if (m_cnt[i] == 0) begin
                m_tc[i] = 1; m_unf[i] = 1;
                m_cnt[i] = P_SAT[i] ? 0 : (m_cnt[i] - 1 + P_MAX[i] + 1) % (P_MAX[i] + 1);
              end else begin
                m_cnt[i] = m_cnt[i] - 1;
              end
            end
          end
        end
      end
    end
  endtask

  // One clock edge: the model sees the inputs as sampled by the DUT, then
  // outputs settle before anyone looks at them.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; clr = 0; load = 0; en = 0; up_dn = 0; data = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (o_count[i] !== 8'h00 || o_tc[i] !== 1'b0 || o_ovf[i] !== 1'b0 ||
          o_unf[i] !== 1'b0 || o_le[i] !== 1'b0 || o_at_min[i] !== 1'b1 ||
          o_at_max[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: count=%h tc=%b ovf=%b unf=%b le=%b min=%b max=%b, required count=00 min=1 others 0",
                 i, o_count[i], o_tc[i], o_ovf[i], o_unf[i], o_le[i], o_at_min[i], o_at_max[i]);
      end
    end
    reset = 0;
  endtask

  task automatic test_load_count();
    logic [7:0] exp_c [3] = '{8'hA0, 8'hA1, 8'hA2};
    load = 1; data = 8'hA0;
    tick();
    load = 0; en = 1; up_dn = 1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (o_count[0] !== exp_c[k] || o_tc[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL load_count step %0d: count=%h tc=%b, required count=%h tc=0",
                 k, o_count[0], o_tc[0], exp_c[k]);
      end
    end
    en = 0;
  endtask

  task automatic test_wrap_default();
    load = 1; data = 8'hFE;
    tick();
    load = 0; en = 1; up_dn = 1;
    tick();
    n_checks++;
    if (o_count[0] !== 8'hFF || o_at_max[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_at_max: count=%h at_max=%b, required FF/1", o_count[0], o_at_max[0]);
    end
    tick();
    n_checks++;
    if (o_count[0] !== 8'h00 || o_tc[0] !== 1'b1 || o_ovf[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_over: count=%h tc=%b ovf=%b, required 00/1/1", o_count[0], o_tc[0], o_ovf[0]);
    end
    en = 0;
    tick();
    n_checks++;
    if (o_tc[0] !== 1'b0 || o_ovf[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_tc_pulse: tc=%b ovf=%b, required tc=0 ovf=1", o_tc[0], o_ovf[0]);
    end
    clr = 1;
    tick();
    clr = 0;
    n_checks++;
    if (o_count[0] !== 8'h00 || o_ovf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_clr: count=%h ovf=%b, required 00/0", o_count[0], o_ovf[0]);
    end
  endtask

  task automatic test_mod9_wrap();
    logic [7:0] exp_c [3] = '{8'd9, 8'd8, 8'd7};
    logic       exp_t [3] = '{1'b1, 1'b0, 1'b0};
    load = 1; data = 8'd0;
    tick();
    load = 0; en = 1; up_dn = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (o_count[1] !== exp_c[k] || o_tc[1] !== exp_t[k] || o_unf[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL mod9_down step %0d: count=%0d tc=%b unf=%b, required %0d/%b/1",
                 k, o_count[1], o_tc[1], o_unf[1], exp_c[k], exp_t[k]);
      end
    end
    en = 0; load = 1; data = 8'd12;
    tick();
    load = 0;
    n_checks++;
    if (o_count[1] !== 8'd9 || o_le[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL mod9_load_err: count=%0d load_err=%b, required 9/1", o_count[1], o_le[1]);
    end
    tick();
    n_checks++;
    if (o_le[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mod9_load_err_pulse: load_err=%b, required 0", o_le[1]);
    end
  endtask

  task automatic test_mod9_sat();
    logic exp_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    load = 1; data = 8'd8;
    tick();
    load = 0; en = 1; up_dn = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (o_count[2] !== 8'd9 || o_tc[2] !== exp_t[k]) begin
        n_fail++;
        $display("FAIL mod9_sat step %0d: count=%0d tc=%b, required 9/%b",
                 k, o_count[2], o_tc[2], exp_t[k]);
      end
    end
    n_checks++;
    if (o_ovf[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL mod9_sat_ovf: ovf=%b, required 1", o_ovf[2]);
    end
    en = 0;
  endtask

  task automatic test_prescale();
    logic [7:0] exp_a [9]  = '{8'd5, 8'd5, 8'd6, 8'd6, 8'd6, 8'd7, 8'd7, 8'd7, 8'd8};
    logic       en_b  [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] exp_b [11] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd6, 8'd6, 8'd6, 8'd7, 8'd7, 8'd7, 8'd8};
    up_dn = 1;
    load = 1; data = 8'd5;
    tick();
    load = 0; en = 1;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_checks++;
      if (o_count[3] !== exp_a[k]) begin
        n_fail++;
        $display("FAIL prescale edge %0d: count=%0d, required %0d", k + 1, o_count[3], exp_a[k]);
      end
    end
    load = 1; data = 8'd5; en = 0;
    tick();
    load = 0;
    for (int k = 0; k < 11; k++) begin
      en = en_b[k];
      tick();
      n_checks++;
      if (o_count[3] !== exp_b[k]) begin
        n_fail++;
        $display("FAIL prescale_gap edge %0d: count=%0d, required %0d", k + 1, o_count[3], exp_b[k]);
      end
    end
    en = 0;
  endtask

  task automatic test_priority();
    clr = 1; load = 1; data = 8'h10; en = 1; up_dn = 1;
    tick();
    clr = 0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (o_count[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL prio_clr_over_load[%0d]: count=%h, required 00", i, o_count[i]);
      end
    end
    data = 8'hFF;
    tick();
    load = 0;
    tick();
    tick();
    load = 0;
    reset = 1; load = 1; data = 8'h55;
    tick();
    reset = 0; load = 0; en = 0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (o_count[i] !== 8'h00 || o_tc[i] !== 1'b0 || o_ovf[i] !== 1'b0 ||
          o_unf[i] !== 1'b0 || o_le[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL prio_reset[%0d]: count=%h tc=%b ovf=%b unf=%b le=%b, required all 0",
                 i, o_count[i], o_tc[i], o_ovf[i], o_unf[i], o_le[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) < 2);
      clr   = ($urandom_range(0, 99) < 3);
      load  = ($urandom_range(0, 99) < 8);
      en    = ($urandom_range(0, 99) < 80);
      up_dn = ($urandom_range(0, 99) < ((n / 150) % 2 == 0 ? 80 : 20));
      data  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(240, 255));
      tick();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (o_count[i] !== 8'(m_cnt[i]) || o_tc[i] !== m_tc[i] || o_ovf[i] !== m_ovf[i] ||
            o_unf[i] !== m_unf[i] || o_le[i] !== m_le[i] ||
            o_at_max[i] !== (m_cnt[i] == P_MAX[i]) || o_at_min[i] !== (m_cnt[i] == 0)) begin
          n_fail++;
          $display("FAIL random[%0d] cyc %0d: count=%0d tc=%b ovf=%b unf=%b le=%b max=%b min=%b, required %0d/%b/%b/%b/%b/%b/%b",
                   i, n, o_count[i], o_tc[i], o_ovf[i], o_unf[i], o_le[i], o_at_max[i], o_at_min[i],
                   m_cnt[i], m_tc[i], m_ovf[i], m_unf[i], m_le[i],
                   (m_cnt[i] == P_MAX[i]), (m_cnt[i] == 0));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_load_count();
    test_wrap_default();
    test_mod9_wrap();
    test_mod9_sat();
    test_prescale();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the team's 8-bit load/enable up counter.
- Adds:
  - Programmable width and modulus.
  - Up/down direction.
  - Wrap or saturate mode.
  - Enable prescaler.
  - Terminal-count pulse, boundary flags and sticky overflow/underflow flags.
- Used as a general event/timer counter in datapath and control blocks.

Parameters:
WIDTH, 8, counter width in bits (>=2)
MOD_MAX, 2**WIDTH-1, highest count value; counter range is 0..MOD_MAX (must be <= 2**WIDTH-1)
SAT_MODE, 0, 0 = wrap at boundaries, 1 = saturate at boundaries
PRESCALE, 1, number of enabled cycles per count step (>=1; 1 = step every enabled cycle)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
clr  input  1  synchronous clear of count, prescaler and sticky flags
load  input  1  load data into count
data  input  WIDTH  load value
en  input  1  count enable
up_dn  input  1  direction: 1 = up, 0 = down
count  output  WIDTH  registered count value
tc  output  1  registered one-cycle terminal-count pulse
at_max  output  1  combinational, count == MOD_MAX
at_min  output  1  combinational, count == 0
ovf  output  1  sticky: an up-step occurred at MOD_MAX
unf  output  1  sticky: a down-step occurred at 0
load_err  output  1  registered one-cycle pulse: load value exceeded MOD_MAX

Behaviour:
- Reset/clear values:
  - reset=1 at an edge: count=0, tc=0, ovf=0, unf=0, load_err=0, prescaler=0.
  - reset dominates all other inputs and takes effect immediately on a mid-count reset.
- Per-edge priority: reset > clr > load > en. Exactly one action per edge.
- clr: count=0, prescaler=0, ovf=0, unf=0, tc=0, load_err=0.
- load (data <= MOD_MAX): count=data; prescaler=0; tc=0; load_err=0.
- load (data > MOD_MAX): count=MOD_MAX; load_err=1 for one cycle; tc=0.
- A load ignores en and up_dn in the same cycle, and flags are not affected.
- Prescaler:
  - Internal counter 0..PRESCALE-1, advanced only on edges where en=1 and no higher-priority action occurs.
  - A step occurs on the edge where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - PRESCALE=1: step on every enabled edge.
  - en=0: prescaler and count hold.
- Step up (up_dn=1):
  - count < MOD_MAX: count+1, tc=0.
  - count == MOD_MAX, SAT_MODE=0: count=0, tc=1, ovf=1.
  - count == MOD_MAX, SAT_MODE=1: count holds at MOD_MAX, tc=1, ovf=1.
- Step down (up_dn=0):
  - count > 0: count-1, tc=0.
  - count == 0, SAT_MODE=0: count=MOD_MAX, tc=1, unf=1.
  - count == 0, SAT_MODE=1: count holds at 0, tc=1, unf=1.
- tc:
  - High for exactly the one cycle after a boundary step.
  - Deasserts on the next edge unless another boundary step occurs (e.g. saturated counter with PRESCALE=1 and en held: tc stays high continuously).
  - Non-stepping enabled edges (prescaler not at terminal) drive tc=0.
- ovf/unf: set as above, held until reset or clr. Both may be set at once.
- load_err: one-cycle pulse; cleared on the next edge unless another out-of-range load occurs.
- A direction change takes effect on the next step. up_dn is sampled only on step edges.
- Arithmetic:
  - Internally WIDTH bits; comparisons are against MOD_MAX, never the natural WIDTH overflow.
  - With MOD_MAX < 2**WIDTH-1 the count never leaves 0..MOD_MAX.
- Latency:
  - count, tc and load_err update one edge after the qualifying inputs.
  - at_max/at_min follow count combinationally.

Test Plan:
- Defaults, reset=1 for 2 cycles, then load=1 data=8'hA0 for one edge, then en=1 up_dn=1 -> count 0x00 during reset, 0xA0 after load, then 0xA1, 0xA2 on successive edges; tc=0.
- Defaults: load 8'hFE, en=1 up -> count 0xFF (at_max=1), then 0x00 with tc=1 for one cycle and ovf=1 sticky; clr -> count=0, ovf=0.
- MOD_MAX=9, SAT_MODE=0: load 0, en=1 up_dn=0 -> count 9, tc=1, unf=1; continue -> 8, 7, tc=0. Load 12 -> count=9, load_err=1 for one cycle.
- MOD_MAX=9, SAT_MODE=1: load 8, en=1 up for 4 edges -> 9, 9, 9, 9; tc high on edges 2-4; ovf=1; count never 0.
- PRESCALE=3, defaults otherwise: load 5, en=1 up for 9 edges -> count 6 after edge 3, 7 after edge 6, 8 after edge 9. Toggling en=0 for 2 edges mid-sequence delays the steps by exactly 2 edges.
- Priority: load=1 data=0x10 with clr=1 and en=1 -> count=0 (clr wins). Reset=1 asserted mid-count with load=1 -> count=0, all flags 0.
